// File: rtl/fpnew_opgroup_share_arb_if.sv
// Handshake bundle between per-lane issue queues, the shared-group arbiter
// and the FP operation-group instance.
interface fpnew_opgroup_share_arb_if #(
    parameter int unsigned NumReq       = 4,
    parameter int unsigned PayloadWidth = 128,
    parameter int unsigned RspWidth     = 38,
    parameter int unsigned TagWidth     = 4,
    parameter int unsigned IdxWidth     = (NumReq > 1) ? $clog2(NumReq) : 1
);
    logic [NumReq-1:0]                         req_valid_i;
    logic [NumReq-1:0]                         req_ready_o;
    logic [NumReq-1:0][PayloadWidth-1:0]       req_payload_i;
    logic [NumReq-1:0][TagWidth-1:0]           req_tag_i;
    logic                                      opg_valid_o;
    logic                                      opg_ready_i;
    logic [PayloadWidth-1:0]                   opg_payload_o;
    logic [IdxWidth+TagWidth-1:0]              opg_tag_o;
    logic                                      opg_rsp_valid_i;
    logic                                      opg_rsp_ready_o;
    logic [RspWidth-1:0]                       opg_rsp_data_i;
    logic [IdxWidth+TagWidth-1:0]              opg_rsp_tag_i;
    logic [NumReq-1:0]                         rsp_valid_o;
    logic [NumReq-1:0]                         rsp_ready_i;
    logic [RspWidth-1:0]                       rsp_data_o;
    logic [TagWidth-1:0]                       rsp_tag_o;

    modport slave (
        input  req_valid_i, req_payload_i, req_tag_i, opg_ready_i,
        input  opg_rsp_valid_i, opg_rsp_data_i, opg_rsp_tag_i, rsp_ready_i,
        output req_ready_o, opg_valid_o, opg_payload_o, opg_tag_o,
        output opg_rsp_ready_o, rsp_valid_o, rsp_data_o, rsp_tag_o
    );

    modport master (
        output req_valid_i, req_payload_i, req_tag_i, opg_ready_i,
        output opg_rsp_valid_i, opg_rsp_data_i, opg_rsp_tag_i, rsp_ready_i,
        input  req_ready_o, opg_valid_o, opg_payload_o, opg_tag_o,
        input  opg_rsp_ready_o, rsp_valid_o, rsp_data_o, rsp_tag_o
    );
endinterface

// File: rtl/fpnew_opgroup_share_arb.sv
// Round-robin share of one FP operation group among NumReq issue ports,
// with per-requester credit counters and tag-prefix response routing.
module fpnew_opgroup_share_arb #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned PayloadWidth   = 128,
    parameter int unsigned RspWidth       = 38,
    parameter int unsigned TagWidth       = 4,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    fpnew_opgroup_share_arb_if.slave io,
    output logic busy_o
);
    localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

    typedef logic [IdxWidth-1:0] idx_t;
    typedef logic [CntWidth-1:0] cnt_t;

    cnt_t [NumReq-1:0] cnt_q, cnt_d;
    idx_t              prio_q, prio_d;
    idx_t              lock_idx_q, lock_idx_d;
    logic              lock_q, lock_d;

    idx_t              sel, rsp_idx;
    logic              sel_vld, issue, rsp_ok, rsp_go;
    logic [NumReq-1:0] elig, req_rdy, iss_vec, ret_vec, rsp_sel, cnt_zero;

    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            elig[i]     = io.req_valid_i[i] && (cnt_q[i] < MaxCnt);
            cnt_zero[i] = (cnt_q[i] == '0);
        end
        if (lock_q) begin
            sel     = lock_idx_q;
            sel_vld = io.req_valid_i[lock_idx_q];
        end else begin
            // first eligible requester at or after prio_q, wrapping
            for (int k = 0; k < NumReq; k++) begin
                if (!sel_vld && elig[(int'(prio_q) + k) % NumReq]) begin
                    sel_vld = 1'b1;
                    sel     = idx_t'((int'(prio_q) + k) % NumReq);
                end
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        if (sel_vld && !flush_i) begin
            req_rdy[sel] = io.opg_ready_i;
        end
    end

    assign issue            = sel_vld && !flush_i && io.opg_ready_i;
    assign iss_vec          = req_rdy & io.req_valid_i;
    assign io.req_ready_o   = req_rdy;
    assign io.opg_valid_o   = sel_vld && !flush_i;
    assign io.opg_payload_o = io.req_payload_i[sel];
    assign io.opg_tag_o     = {sel, io.req_tag_i[sel]};

    assign rsp_idx = io.opg_rsp_tag_i[IdxWidth+TagWidth-1 -: IdxWidth];

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            rsp_sel[i] = (rsp_idx == idx_t'(i));
        end
    end

    // out-of-range indices match no requester and are acked and dropped
    assign rsp_ok  = |rsp_sel;
    assign rsp_go  = io.opg_rsp_valid_i && !flush_i;
    assign ret_vec = rsp_go ? (rsp_sel & io.rsp_ready_i) : '0;

    assign io.rsp_valid_o     = rsp_go ? rsp_sel : '0;
    assign io.opg_rsp_ready_o = flush_i || !rsp_ok || |(rsp_sel & io.rsp_ready_i);
    assign io.rsp_data_o      = io.opg_rsp_data_i;
    assign io.rsp_tag_o       = io.opg_rsp_tag_i[TagWidth-1:0];

    assign busy_o = |cnt_q;

    always_comb begin
        cnt_d      = cnt_q;
        prio_d     = prio_q;
        lock_d     = sel_vld && !flush_i && !io.opg_ready_i;
        lock_idx_d = lock_d ? sel : lock_idx_q;
        if (issue) begin
            prio_d = idx_t'((int'(sel) + 1) % NumReq);
        end
        for (int i = 0; i < NumReq; i++) begin
            if (iss_vec[i] && !ret_vec[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (!iss_vec[i] && ret_vec[i] && !cnt_zero[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
        if (flush_i) begin
            cnt_d  = '0;
            prio_d = '0;
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            prio_q     <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (lock_q && !flush_i) |-> io.req_valid_i[lock_idx_q]);

    a_rsp_idx: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_go |-> rsp_ok);

    a_ret_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (ret_vec & cnt_zero) == '0);
endmodule

// File: tb/tb_fpnew_opgroup_share_arb.sv
// Directed bench for the shared op-group arbiter: a vector table on a
// 4-credit instance plus credit-limit and flush sequences.
module tb_fpnew_opgroup_share_arb;
    logic clk = 1'b0;
    logic rst_n;
    logic flush_a, flush_b, busy_a, busy_b;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fpnew_opgroup_share_arb_if #(
        .NumReq(4), .PayloadWidth(16), .RspWidth(8), .TagWidth(4)
    ) io_a ();
    fpnew_opgroup_share_arb_if #(
        .NumReq(4), .PayloadWidth(16), .RspWidth(8), .TagWidth(4)
    ) io_b ();

    fpnew_opgroup_share_arb #(
        .NumReq(4), .PayloadWidth(16), .RspWidth(8),
        .TagWidth(4), .MaxOutstanding(4)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_a),
        .io(io_a.slave), .busy_o(busy_a)
    );

    fpnew_opgroup_share_arb #(
        .NumReq(4), .PayloadWidth(16), .RspWidth(8),
        .TagWidth(4), .MaxOutstanding(2)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_b),
        .io(io_b.slave), .busy_o(busy_b)
    );

    typedef struct {
        logic       fl;
        logic [3:0] vld;
        logic       ordy;
        logic       rvld;
        logic [5:0] rtag;
        logic [3:0] rrdy;
        logic       e_ovld;
        logic [5:0] e_otag;
        logic [3:0] e_rdy;
        logic [3:0] e_rspv;
        logic       e_orr;
        logic       e_busy;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic fl, input logic [3:0] vld, input logic ordy,
        input logic rvld, input logic [5:0] rtag, input logic [3:0] rrdy,
        input logic eov, input logic [5:0] eot, input logic [3:0] erdy,
        input logic [3:0] erv, input logic eorr, input logic ebusy);
        vec_t v;
        v.fl = fl; v.vld = vld; v.ordy = ordy;
        v.rvld = rvld; v.rtag = rtag; v.rrdy = rrdy;
        v.e_ovld = eov; v.e_otag = eot; v.e_rdy = erdy;
        v.e_rspv = erv; v.e_orr = eorr; v.e_busy = ebusy;
        return v;
    endfunction

    function automatic logic [15:0] pay(input logic [1:0] k);
        return 16'hA0A0 + 16'(k);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string nm);
        @(negedge clk);
        flush_a = v.fl;
        io_a.req_valid_i = v.vld;
        io_a.opg_ready_i = v.ordy;
        io_a.opg_rsp_valid_i = v.rvld;
        io_a.opg_rsp_tag_i = v.rtag;
        io_a.rsp_ready_i = v.rrdy;
        #1;
        chk({nm, ".ovld"}, 32'(io_a.opg_valid_o), 32'(v.e_ovld));
        if (v.e_ovld) begin
            chk({nm, ".otag"}, 32'(io_a.opg_tag_o), 32'(v.e_otag));
            chk({nm, ".opay"}, 32'(io_a.opg_payload_o),
                32'(pay(v.e_otag[5:4])));
        end
        chk({nm, ".rdy"}, 32'(io_a.req_ready_o), 32'(v.e_rdy));
        chk({nm, ".rspv"}, 32'(io_a.rsp_valid_o), 32'(v.e_rspv));
        chk({nm, ".orr"}, 32'(io_a.opg_rsp_ready_o), 32'(v.e_orr));
        chk({nm, ".busy"}, 32'(busy_a), 32'(v.e_busy));
        if (v.rvld && !v.fl) begin
            chk({nm, ".rtag"}, 32'(io_a.rsp_tag_o), 32'(v.rtag[3:0]));
            chk({nm, ".rdata"}, 32'(io_a.rsp_data_o), 32'h5A);
        end
    endtask

    task automatic run_b(input logic rvld, input logic [3:0] erdy,
                         input logic eov, input logic [3:0] erv,
                         input logic ebusy, input string nm);
        @(negedge clk);
        io_b.req_valid_i = 4'b0001;
        io_b.opg_ready_i = 1'b1;
        io_b.opg_rsp_valid_i = rvld;
        io_b.opg_rsp_tag_i = 6'h04;
        io_b.rsp_ready_i = 4'hF;
        #1;
        chk({nm, ".rdy"}, 32'(io_b.req_ready_o), 32'(erdy));
        chk({nm, ".ovld"}, 32'(io_b.opg_valid_o), 32'(eov));
        chk({nm, ".rspv"}, 32'(io_b.rsp_valid_o), 32'(erv));
        chk({nm, ".busy"}, 32'(busy_b), 32'(ebusy));
    endtask

    initial begin
        rst_n = 1'b0;
        flush_a = 1'b0;
        flush_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            io_a.req_payload_i[i] = pay(2'(i));
            io_a.req_tag_i[i] = 4'(4 + i);
            io_b.req_payload_i[i] = pay(2'(i));
            io_b.req_tag_i[i] = 4'(4 + i);
        end
        io_a.req_valid_i = '0; io_a.opg_ready_i = 1'b0;
        io_a.opg_rsp_valid_i = 1'b0; io_a.opg_rsp_tag_i = '0;
        io_a.opg_rsp_data_i = 8'h5A; io_a.rsp_ready_i = '0;
        io_b.req_valid_i = '0; io_b.opg_ready_i = 1'b0;
        io_b.opg_rsp_valid_i = 1'b0; io_b.opg_rsp_tag_i = '0;
        io_b.opg_rsp_data_i = 8'h5A; io_b.rsp_ready_i = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst.ovld", 32'(io_a.opg_valid_o), 0);
        chk("rst.rdy", 32'(io_a.req_ready_o), 0);
        chk("rst.rspv", 32'(io_a.rsp_valid_o), 0);
        chk("rst.busy_a", 32'(busy_a), 0);
        chk("rst.busy_b", 32'(busy_b), 0);
        chk("rst.orr0", 32'(io_a.opg_rsp_ready_o), 0);
        io_a.rsp_ready_i = 4'b0001;
        #1;
        chk("rst.orr1", 32'(io_a.opg_rsp_ready_o), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // round-robin from prio 0
        tv.push_back(mk(0, 4'hF, 1, 0, 6'h00, 4'hF, 1, 6'h04, 4'h1, 4'h0, 1, 0));
        tv.push_back(mk(0, 4'hF, 1, 0, 6'h00, 4'hF, 1, 6'h15, 4'h2, 4'h0, 1, 1));
        tv.push_back(mk(0, 4'hF, 1, 0, 6'h00, 4'hF, 1, 6'h26, 4'h4, 4'h0, 1, 1));
        tv.push_back(mk(0, 4'hF, 1, 0, 6'h00, 4'hF, 1, 6'h37, 4'h8, 4'h0, 1, 1));
        tv.push_back(mk(0, 4'hF, 1, 0, 6'h00, 4'hF, 1, 6'h04, 4'h1, 4'h0, 1, 1));
        // response routing, blocked then accepted
        tv.push_back(mk(0, 4'h0, 1, 1, 6'h3A, 4'h7, 0, 6'h00, 4'h0, 4'h8, 0, 1));
        tv.push_back(mk(0, 4'h0, 1, 1, 6'h3A, 4'hF, 0, 6'h00, 4'h0, 4'h8, 1, 1));
        tv.push_back(mk(0, 4'h0, 1, 1, 6'h13, 4'hF, 0, 6'h00, 4'h0, 4'h2, 1, 1));
        tv.push_back(mk(0, 4'h0, 1, 1, 6'h04, 4'hF, 0, 6'h00, 4'h0, 4'h1, 1, 1));
        // issue and retire on req0 with count 1
        tv.push_back(mk(0, 4'h1, 1, 1, 6'h04, 4'hF, 1, 6'h04, 4'h1, 4'h1, 1, 1));
        tv.push_back(mk(0, 4'h0, 1, 1, 6'h26, 4'hF, 0, 6'h00, 4'h0, 4'h4, 1, 1));
        tv.push_back(mk(0, 4'h0, 1, 0, 6'h00, 4'hF, 0, 6'h00, 4'h0, 4'h0, 1, 1));
        tv.push_back(mk(0, 4'h0, 1, 1, 6'h04, 4'hF, 0, 6'h00, 4'h0, 4'h1, 1, 1));
        tv.push_back(mk(0, 4'h0, 1, 0, 6'h00, 4'hF, 0, 6'h00, 4'h0, 4'h0, 1, 0));
        // move prio to 2, then lock on req1 while req2 is also valid
        tv.push_back(mk(0, 4'h2, 1, 0, 6'h00, 4'hF, 1, 6'h15, 4'h2, 4'h0, 1, 0));
        tv.push_back(mk(0, 4'h0, 1, 1, 6'h15, 4'hF, 0, 6'h00, 4'h0, 4'h2, 1, 1));
        tv.push_back(mk(0, 4'h2, 0, 0, 6'h00, 4'hF, 1, 6'h15, 4'h0, 4'h0, 1, 0));
        tv.push_back(mk(0, 4'h6, 0, 0, 6'h00, 4'hF, 1, 6'h15, 4'h0, 4'h0, 1, 0));
        tv.push_back(mk(0, 4'h6, 0, 0, 6'h00, 4'hF, 1, 6'h15, 4'h0, 4'h0, 1, 0));
        tv.push_back(mk(0, 4'h6, 1, 0, 6'h00, 4'hF, 1, 6'h15, 4'h2, 4'h0, 1, 0));
        tv.push_back(mk(0, 4'h6, 1, 0, 6'h00, 4'hF, 1, 6'h26, 4'h4, 4'h0, 1, 1));
        tv.push_back(mk(0, 4'h0, 1, 1, 6'h15, 4'hF, 0, 6'h00, 4'h0, 4'h2, 1, 1));
        tv.push_back(mk(0, 4'h0, 1, 1, 6'h26, 4'hF, 0, 6'h00, 4'h0, 4'h4, 1, 1));
        tv.push_back(mk(0, 4'h0, 1, 0, 6'h00, 4'hF, 0, 6'h00, 4'h0, 4'h0, 1, 0));

        for (int i = 0; i < tv.size(); i++) begin
            run(tv[i], $sformatf("v%0d", i));
        end

        // flush with counts {2,1,0,3}, locked on req3, response in flight
        run(mk(0, 4'h8, 1, 0, 6'h00, 4'hF, 1, 6'h37, 4'h8, 4'h0, 1, 0), "f1");
        run(mk(0, 4'h8, 1, 0, 6'h00, 4'hF, 1, 6'h37, 4'h8, 4'h0, 1, 1), "f2");
        run(mk(0, 4'h8, 1, 0, 6'h00, 4'hF, 1, 6'h37, 4'h8, 4'h0, 1, 1), "f3");
        run(mk(0, 4'h1, 1, 0, 6'h00, 4'hF, 1, 6'h04, 4'h1, 4'h0, 1, 1), "f4");
        run(mk(0, 4'h1, 1, 0, 6'h00, 4'hF, 1, 6'h04, 4'h1, 4'h0, 1, 1), "f5");
        run(mk(0, 4'h2, 1, 0, 6'h00, 4'hF, 1, 6'h15, 4'h2, 4'h0, 1, 1), "f6");
        run(mk(0, 4'h8, 0, 0, 6'h00, 4'hF, 1, 6'h37, 4'h0, 4'h0, 1, 1), "f7");
        run(mk(1, 4'h8, 1, 1, 6'h15, 4'h0, 0, 6'h00, 4'h0, 4'h0, 1, 1), "f8");
        run(mk(0, 4'h0, 1, 0, 6'h00, 4'hF, 0, 6'h00, 4'h0, 4'h0, 1, 0), "f9");
        run(mk(0, 4'hA, 0, 0, 6'h00, 4'hF, 1, 6'h15, 4'h0, 4'h0, 1, 0), "f10");
        run(mk(0, 4'hA, 1, 0, 6'h00, 4'hF, 1, 6'h15, 4'h2, 4'h0, 1, 0), "f11");
        @(negedge clk);
        io_a.req_valid_i = '0;

        // credit limit of 2 on the second instance
        run_b(0, 4'h1, 1, 4'h0, 0, "c1");
        run_b(0, 4'h1, 1, 4'h0, 1, "c2");
        run_b(0, 4'h0, 0, 4'h0, 1, "c3");
        run_b(1, 4'h0, 0, 4'h1, 1, "c4");
        run_b(0, 4'h1, 1, 4'h0, 1, "c5");
        run_b(0, 4'h0, 0, 4'h0, 1, "c6");
        @(negedge clk);
        io_b.req_valid_i = '0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
